// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param_if
// Purpose  : Serial data, pattern reload and status bundle for seq_detector_param.
// Revision : 1.0
// ============================================================================
interface seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               in;
    logic               in_valid;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               clr_cnt;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic [PAT_LEN-1:0] pattern;

    modport master (
        output in, in_valid, pat_load, pat_in, clr_cnt,
        input  out, match_cnt, pattern
    );

    modport slave (
        input  in, in_valid, pat_load, pat_in, clr_cnt,
        output out, match_cnt, pattern
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised serial pattern detector with reloadable pattern,
//            overlap/non-overlap modes and a saturating match counter.
// Revision : 1.0
// ============================================================================
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b0110),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam int                  c_fill_w  = $clog2(PAT_LEN + 1);
    localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_LEN);
    localparam logic [c_fill_w-1:0] c_fill_arm = c_fill_w'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max  = '1;

    logic [PAT_LEN-1:0]  r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic                r_out;
    logic [PAT_LEN-1:0]  r_pattern;
    logic [CNT_W-1:0]    r_match_cnt;

    logic [PAT_LEN-1:0]  w_nhist;
    logic                w_match;
    logic                w_sample;
    logic                w_match_evt;
    logic                w_flush;

    assign w_sample    = bus.in_valid & ~bus.pat_load;
    assign w_nhist     = {r_hist[PAT_LEN-2:0], bus.in};
    // Only a history with at least PAT_LEN-1 valid bits plus this one can match.
    assign w_match     = (w_nhist == r_pattern) && (r_fill >= c_fill_arm);
    assign w_match_evt = w_sample & w_match;

    generate
        if (OVERLAP != 0) begin : g_overlap
            assign w_flush = 1'b0;
        end else begin : g_no_overlap
            assign w_flush = w_match_evt;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_pattern <= PATTERN;
        end else begin
            r_out <= 1'b0;
            if (bus.pat_load) begin
                r_pattern <= bus.pat_in;
                r_fill    <= '0;
            end else if (bus.in_valid) begin
                r_hist <= w_nhist;
                r_out  <= w_match;
                if (w_flush) begin
                    r_fill <= '0;
                end else if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_match_cnt <= '0;
        end else if (w_match_evt && (r_match_cnt != c_cnt_max)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign bus.out       = r_out;
    assign bus.match_cnt = r_match_cnt;
    assign bus.pattern   = r_pattern;

endmodule
`default_nettype wire
